// File: rtl/dmem_line_responder_pkg.sv
// Shared widths and FSM state type for the data-memory line responder.
package dmem_line_responder_pkg;

    localparam int WORD                = 32;
    localparam int CACHE_LINE_WIDTH    = 128;
    localparam int CACHE_LINE_BYTE_LOG = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_DRAIN,
        ST_WR,
        ST_RESP
    } state_e;

endpackage

// File: rtl/dmem_line_responder_rd_lat_pipe.sv
// Shift pipe that tags each issued RAM read with its line-word index,
// so the tag emerges exactly when the RAM returns that word.
module dmem_line_responder_rd_lat_pipe #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    input  logic [IDX_W-1:0] in_idx_i,
    output logic             out_valid_o,
    output logic [IDX_W-1:0] out_idx_o
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic             vld_in;
            logic [IDX_W-1:0] idx_in;
            logic             vld_q;
            logic [IDX_W-1:0] idx_q;

            if (gi == 0) begin : g_src
                assign vld_in = in_valid_i;
                assign idx_in = in_idx_i;
            end else begin : g_src
                assign vld_in = g_stage[gi-1].vld_q;
                assign idx_in = g_stage[gi-1].idx_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= 1'b0;
                    idx_q <= '0;
                end else begin
                    vld_q <= vld_in;
                    idx_q <= idx_in;
                end
            end
        end
    endgenerate

    assign out_valid_o = g_stage[DEPTH-1].vld_q;
    assign out_idx_o   = g_stage[DEPTH-1].idx_q;

endmodule

// File: rtl/dmem_line_responder.sv
// Memory-side responder: line loads as LINE_WORDS back-to-back RAM reads
// assembled into one line, single-word stores, one-cycle ready pulse.
module dmem_line_responder
    import dmem_line_responder_pkg::*;
#(
    parameter int RAM_ADDR_W = 14,
    parameter int RAM_LAT    = 1,
    parameter int LINE_WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        memory_valid,
    input  logic                        memory_for_store,
    input  logic [WORD-1:0]             load_store_addr,
    input  logic [WORD-1:0]             data_to_mem,
    output logic                        memory_ready,
    output logic [CACHE_LINE_WIDTH-1:0] data_from_mem,
    output logic                        ram_en,
    output logic                        ram_we,
    output logic [RAM_ADDR_W-1:0]       ram_addr,
    output logic [WORD-1:0]             ram_wdata,
    input  logic [WORD-1:0]             ram_rdata
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int CNT_W = $clog2(LINE_WORDS + 1);

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            issue_q, issue_d;
    logic [CNT_W-1:0]            ret_q, ret_d;
    logic [RAM_ADDR_W-1:0]       waddr_q, waddr_d;
    logic [WORD-1:0]             wdata_q, wdata_d;
    logic [CACHE_LINE_WIDTH-1:0] line_q;

    logic             issue_v;
    logic             ret_valid;
    logic [IDX_W-1:0] ret_idx;

    // Byte-lane bits and address bits beyond the RAM size are ignored (wrap).
    wire unused_addr_bits = ^{load_store_addr[WORD-1:RAM_ADDR_W+2], load_store_addr[1:0]};

    dmem_line_responder_rd_lat_pipe #(
        .DEPTH (RAM_LAT),
        .IDX_W (IDX_W)
    ) u_rd_lat_pipe (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (issue_v),
        .in_idx_i    (issue_q),
        .out_valid_o (ret_valid),
        .out_idx_o   (ret_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            issue_q <= '0;
            ret_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
            ret_q   <= ret_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            if (ret_valid) begin
                line_q[ret_idx*WORD +: WORD] <= ram_rdata;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        issue_d      = issue_q;
        ret_d        = ret_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        issue_v      = 1'b0;
        memory_ready = 1'b0;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;

        if (ret_valid) begin
            ret_d = ret_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (memory_valid) begin
                    waddr_d = load_store_addr[RAM_ADDR_W+1:2];
                    wdata_d = data_to_mem;
                    issue_d = '0;
                    ret_d   = '0;
                    state_d = memory_for_store ? ST_WR : ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                ram_en   = 1'b1;
                ram_addr = {waddr_q[RAM_ADDR_W-1:IDX_W], issue_q};
                issue_v  = 1'b1;
                issue_d  = issue_q + 1'b1;
                if (issue_q == IDX_W'(LINE_WORDS - 1)) begin
                    state_d = ST_RD_DRAIN;
                end
            end
            ST_RD_DRAIN: begin
                // Looking at ret_d lets a return landing this cycle finish the drain.
                if (ret_d == CNT_W'(LINE_WORDS)) begin
                    state_d = ST_RESP;
                end
            end
            ST_WR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = waddr_q;
                ram_wdata = wdata_q;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                memory_ready = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign data_from_mem = line_q;

endmodule
